// File: rtl/sym_conv_mac.sv
// sym_conv_mac
//   Final stage of the symmetric Gaussian convolver. It takes the pre-added
//   kernel terms, multiplies each one by a programmable unsigned coefficient,
//   sums the products in a pipelined binary adder tree, then rounds half up
//   and saturates the sum to one output pixel. It accepts one sample per clock
//   and has no backpressure.
//
//   The coefficients are double-buffered. Writes land in a shadow bank. A
//   commit copies shadow -> active only when no sample is at the input or in
//   stage 1, so every window is computed with a single coefficient set.
//
// Ports
//   axi_clk, axi_rstn        clock, asynchronous active-low reset
//   svalid                   input sample valid
//   sym1                     centre term (W bits)
//   sym4                     S4 four-fold sums, W+2 bits each, packed [S4-1:0]
//   sym8_0, sym8_1           S8 eight-fold half sums; pair k shares a coefficient
//   coef_wr/addr/data        shadow coefficient write port
//   coef_commit              request a shadow -> active copy
//   coef_busy                commit requested but not yet applied
//   pix_valid, pix_out       filtered pixel; pix_out holds between valids
module sym_conv_mac #(
  parameter  int IMAGE_DATA_WIDTH = 8,
  parameter  int CONV_KERNEL_SIZE = 11,
  parameter  int COEF_WIDTH       = 18,
  parameter  int COEF_FRAC        = 16,
  localparam int W     = IMAGE_DATA_WIDTH,
  localparam int S4    = CONV_KERNEL_SIZE - 1,
  localparam int S8    = ((CONV_KERNEL_SIZE - 1) * (CONV_KERNEL_SIZE - 3)) / 8,
  localparam int NCOEF = 1 + S4 + S8,
  localparam int AW    = $clog2(NCOEF)
) (
  input  logic                  axi_clk,
  input  logic                  axi_rstn,
  input  logic                  svalid,
  input  logic [W-1:0]          sym1,
  input  logic [S4*(W+2)-1:0]   sym4,
  input  logic [S8*(W+2)-1:0]   sym8_0,
  input  logic [S8*(W+2)-1:0]   sym8_1,
  input  logic                  coef_wr,
  input  logic [AW-1:0]         coef_addr,
  input  logic [COEF_WIDTH-1:0] coef_data,
  input  logic                  coef_commit,
  output logic                  coef_busy,
  output logic                  pix_valid,
  output logic [W-1:0]          pix_out
);

  localparam int L  = $clog2(NCOEF);       // adder tree depth
  localparam int TW = W + 3;               // term width after the sym8 merge
  localparam int PW = TW + COEF_WIDTH;     // product width
  localparam int SW = PW + L;              // tree sum width, cannot overflow
  localparam int NP = 1 << L;              // leaves, zero-padded past NCOEF
  localparam int RW = SW - COEF_FRAC + 1;  // rounded width (+1 for round carry)
  localparam logic [AW:0] NCOEF_L = (AW + 1)'(NCOEF);

  function automatic logic [RW-1:0] round_half_up(input logic [SW-1:0] s);
    logic [SW:0] t;
    t = {1'b0, s} + ((SW + 1)'(1) << (COEF_FRAC - 1));
    return t[SW:COEF_FRAC];
  endfunction

  function automatic logic [W-1:0] saturate(input logic [RW-1:0] r);
    if (r > RW'((1 << W) - 1)) return '1;
    else                       return r[W-1:0];
  endfunction

  // ---------------- coefficient banks and commit handshake ----------------
  logic [COEF_WIDTH-1:0] shadow_q [NCOEF];
  logic [COEF_WIDTH-1:0] active_q [NCOEF];
  logic                  pend_q, pend_d, copy_en;
  logic                  vld_p1_q;

  // The copy waits for an empty input and an empty stage 1. That way no
  // sample can read the active bank at stage 2 while the bank changes.
  always_comb begin
    copy_en = (pend_q | coef_commit) & ~svalid & ~vld_p1_q;
    pend_d  = (pend_q | coef_commit) & ~copy_en;
  end

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      pend_q <= 1'b0;
      for (int i = 0; i < NCOEF; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      if (coef_wr && ({1'b0, coef_addr} < NCOEF_L))
        shadow_q[coef_addr] <= coef_data;
      // Non-blocking copy reads the pre-write shadow on a coincident write.
      if (copy_en)
        for (int i = 0; i < NCOEF; i++) active_q[i] <= shadow_q[i];
    end
  end

  assign coef_busy = pend_q;

  // ---------------- stage 1: register terms, merge sym8 halves ----------------
  logic [TW-1:0] term_p1_q [NCOEF];

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      vld_p1_q <= 1'b0;
      for (int i = 0; i < NCOEF; i++) term_p1_q[i] <= '0;
    end else begin
      vld_p1_q <= svalid;
      if (svalid) begin
        term_p1_q[0] <= TW'(sym1);
        for (int i = 0; i < S4; i++)
          term_p1_q[1+i] <= TW'(sym4[i*(W+2) +: (W+2)]);
        for (int k = 0; k < S8; k++)
          term_p1_q[1+S4+k] <= TW'(sym8_0[k*(W+2) +: (W+2)])
                             + TW'(sym8_1[k*(W+2) +: (W+2)]);
      end
    end
  end

  // ---------------- stage 2: multiply by the active coefficients ----------------
  // vld_t_q[0] marks stage 2. vld_t_q[j] marks adder tree level j.
  logic [PW-1:0] prod_p2_q [NCOEF];
  logic [L:0]    vld_t_q;

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      vld_t_q <= '0;
      for (int i = 0; i < NCOEF; i++) prod_p2_q[i] <= '0;
    end else begin
      vld_t_q <= {vld_t_q[L-1:0], vld_p1_q};
      if (vld_p1_q)
        for (int i = 0; i < NCOEF; i++)
          prod_p2_q[i] <= PW'(term_p1_q[i]) * PW'(active_q[i]);
    end
  end

  // ---------------- stages 3..2+L: heap-indexed adder tree ----------------
  // Node n has children 2n and 2n+1. Indices NP..2NP-1 are the leaves, so the
  // root is node 1. Nodes at depth d are registered at tree level L-d.
  logic [SW-1:0] leaf_w [NP];
  logic [SW-1:0] sum_w  [1:NP-1];
  logic [NP-1:1] en_w;
  logic [SW-1:0] node_q [1:NP-1];

  for (genvar i = 0; i < NP; i++) begin : g_leaf
    if (i < NCOEF) begin : g_used
      assign leaf_w[i] = SW'(prod_p2_q[i]);
    end else begin : g_pad
      assign leaf_w[i] = '0;
    end
  end

  for (genvar n = 1; n < NP; n++) begin : g_node
    localparam int LVL = L - ($clog2(n + 1) - 1);
    if (2 * n >= NP) begin : g_bottom
      assign sum_w[n] = leaf_w[2*n-NP] + leaf_w[2*n+1-NP];
    end else begin : g_inner
      assign sum_w[n] = node_q[2*n] + node_q[2*n+1];
    end
    assign en_w[n] = vld_t_q[LVL-1];
  end

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      for (int n = 1; n < NP; n++) node_q[n] <= '0;
    end else begin
      for (int n = 1; n < NP; n++)
        if (en_w[n]) node_q[n] <= sum_w[n];
    end
  end

  // ---------------- stage 3+L: round half up ----------------
  // Rounding and saturation use two registers. This puts pix_valid
  // exactly 3+L edges after the edge that sampled svalid.
  logic          vld_r_q;
  logic [RW-1:0] rnd_q;

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      vld_r_q <= 1'b0;
      rnd_q   <= '0;
    end else begin
      vld_r_q <= vld_t_q[L];
      if (vld_t_q[L]) rnd_q <= round_half_up(node_q[1]);
    end
  end

  // ---------------- output: saturate and hold ----------------
  logic         pix_valid_q;
  logic [W-1:0] pix_out_q;

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      pix_valid_q <= 1'b0;
      pix_out_q   <= '0;
    end else begin
      pix_valid_q <= vld_r_q;
      if (vld_r_q) pix_out_q <= saturate(rnd_q);
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_out   = pix_out_q;

endmodule
